// File: rtl/jpeg_rle_symbolizer.sv
// JPEG run-length symbolizer: turns zig-zag ordered quantized coefficients into
// DC-difference, AC (run,size,amp), ZRL and EOB symbols for the Huffman stage.
module jpeg_rle_symbolizer #(
    parameter int unsigned COEF_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pred_clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COEF_W-1:0] in_coef,
    input  logic              in_sob,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_dc,
    output logic [3:0]        out_run,
    output logic [3:0]        out_size,
    output logic [COEF_W:0]   out_amp,
    output logic              out_eob,
    output logic              sync_err
);
    localparam int unsigned AW = COEF_W + 1;
    localparam int unsigned IW = 6;
    localparam int unsigned ZW = 6;

    typedef enum logic {RUN, FLUSH} state_t;

    // Bit length of |v|; zero maps to category 0.
    function automatic logic [3:0] cat_of(input logic signed [AW-1:0] v);
        logic [AW-1:0] mag;
        mag = v[AW-1] ? AW'(-v) : AW'(v);
        cat_of = 4'd0;
        for (int i = 0; i < int'(AW); i++)
            if (mag[i]) cat_of = 4'(i + 1);
    endfunction

    // Negative values are sent as (v-1) truncated to the category width.
    function automatic logic [AW-1:0] amp_of(input logic signed [AW-1:0] v,
                                             input logic [3:0] c);
        logic [AW-1:0] mask;
        mask = (AW'(1) << c) - AW'(1);
        amp_of = v[AW-1] ? (AW'(v - AW'(1)) & mask) : AW'(v);
    endfunction

    state_t                   state;
    logic [IW-1:0]            idx;
    logic [ZW-1:0]            zrun;
    logic signed [COEF_W-1:0] pred;
    logic [3:0]               hold_size;
    logic [AW-1:0]            hold_amp;

    logic                     load, accept, is_dc;
    logic signed [AW-1:0]     coef_x, pred_x, sym_val;
    logic [3:0]               sym_cat;
    logic [AW-1:0]            sym_amp;

    assign load     = !out_valid || out_ready;
    assign in_ready = !rst && (state == RUN) && load;
    assign accept   = in_valid && in_ready;
    assign is_dc    = in_sob || (idx == '0);
    assign coef_x   = {in_coef[COEF_W-1], in_coef};
    assign pred_x   = pred_clr ? '0 : {pred[COEF_W-1], pred};
    assign sym_val  = is_dc ? (coef_x - pred_x) : coef_x;
    assign sym_cat  = cat_of(sym_val);
    assign sym_amp  = amp_of(sym_val, sym_cat);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            idx       <= '0;
            zrun      <= '0;
            pred      <= '0;
            hold_size <= '0;
            hold_amp  <= '0;
            out_valid <= 1'b0;
            out_dc    <= 1'b0;
            out_run   <= '0;
            out_size  <= '0;
            out_amp   <= '0;
            out_eob   <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            if (pred_clr) pred <= '0;
            if (state == RUN) begin
                if (load) begin
                    out_valid <= 1'b0;
                    out_dc    <= 1'b0;
                    out_run   <= '0;
                    out_size  <= '0;
                    out_amp   <= '0;
                    out_eob   <= 1'b0;
                    if (accept) begin
                        // A DC coefficient always restarts the block at index 1.
                        idx <= is_dc ? IW'(1) : IW'(idx + IW'(1));
                        if (in_sob && idx != '0) sync_err <= 1'b1;
                        if (is_dc) begin
                            pred      <= in_coef;
                            zrun      <= '0;
                            out_valid <= 1'b1;
                            out_dc    <= 1'b1;
                            out_size  <= sym_cat;
                            out_amp   <= sym_amp;
                        end else if (in_coef == '0) begin
                            if (idx == IW'(63)) begin
                                zrun      <= '0;
                                out_valid <= 1'b1;
                                out_eob   <= 1'b1;
                            end else begin
                                zrun <= ZW'(zrun + ZW'(1));
                            end
                        end else if (zrun < ZW'(16)) begin
                            zrun      <= '0;
                            out_valid <= 1'b1;
                            out_run   <= zrun[3:0];
                            out_size  <= sym_cat;
                            out_amp   <= sym_amp;
                        end else begin
                            hold_size <= sym_cat;
                            hold_amp  <= sym_amp;
                            state     <= FLUSH;
                        end
                    end
                end
            end else if (load) begin
                // Drain one ZRL per slot, then the held symbol with the remainder run.
                out_valid <= 1'b1;
                out_dc    <= 1'b0;
                out_eob   <= 1'b0;
                if (zrun >= ZW'(16)) begin
                    zrun     <= ZW'(zrun - ZW'(16));
                    out_run  <= 4'd15;
                    out_size <= '0;
                    out_amp  <= '0;
                end else begin
                    zrun     <= '0;
                    out_run  <= zrun[3:0];
                    out_size <= hold_size;
                    out_amp  <= hold_amp;
                    state    <= RUN;
                end
            end
        end
    end
endmodule

// File: tb/tb_jpeg_rle_symbolizer.sv
// Self-checking bench for jpeg_rle_symbolizer: directed cases plus random blocks
// compared against a symbol-queue reference model.
module tb_jpeg_rle_symbolizer;
    logic        clk = 1'b0;
    logic        rst;
    logic        pred_clr, in_valid, in_ready, in_sob;
    logic [11:0] in_coef;
    logic        out_valid, out_ready, out_dc, out_eob, sync_err;
    logic [3:0]  out_run, out_size;
    logic [12:0] out_amp;

    int n_checks = 0;
    int n_fail   = 0;
    int rmode    = 0;

    logic [22:0] exp_q[$];
    int m_idx, m_zrun, m_pred;
    int blk[64];

    jpeg_rle_symbolizer #(.COEF_W(12)) dut (
        .clk(clk), .rst(rst), .pred_clr(pred_clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_coef(in_coef), .in_sob(in_sob),
        .out_valid(out_valid), .out_ready(out_ready), .out_dc(out_dc),
        .out_run(out_run), .out_size(out_size), .out_amp(out_amp),
        .out_eob(out_eob), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int cat_m(input int v);
        int a, c;
        a = (v < 0) ? -v : v;
        c = 0;
        while (a > 0) begin
            c++;
            a = a / 2;
        end
        return c;
    endfunction

    function automatic logic [22:0] mk(input bit dc, input bit eob, input int run, input int v);
        int c, a;
        c = cat_m(v);
        a = (v >= 0) ? v : v + (1 << c) - 1;
        return {dc, eob, 4'(run), 4'(c), 13'(a)};
    endfunction

    function automatic void model_reset();
        m_idx = 0; m_zrun = 0; m_pred = 0;
        exp_q.delete();
    endfunction

    // Reference: symbols that an accepted coefficient produces, in emission order.
    function automatic void model_accept(input int c, input bit sob, input bit clr);
        if (clr) m_pred = 0;
        if (sob || m_idx == 0) begin
            exp_q.push_back(mk(1'b1, 1'b0, 0, c - m_pred));
            m_pred = c;
            m_zrun = 0;
            m_idx  = 1;
            return;
        end
        if (c == 0) begin
            if (m_idx == 63) begin
                exp_q.push_back(mk(1'b0, 1'b1, 0, 0));
                m_zrun = 0;
            end else begin
                m_zrun++;
            end
        end else begin
            while (m_zrun >= 16) begin
                exp_q.push_back(mk(1'b0, 1'b0, 15, 0));
                m_zrun -= 16;
            end
            exp_q.push_back(mk(1'b0, 1'b0, m_zrun, c));
            m_zrun = 0;
        end
        m_idx = (m_idx + 1) % 64;
    endfunction

    task automatic send_coef(input int c, input bit sob, input bit clr);
        int n;
        bit acc;
        in_valid = 1'b1; in_coef = 12'(c); in_sob = sob; pred_clr = clr;
        n = 0; acc = 1'b0;
        while (!acc && n < 500) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0; in_sob = 1'b0; pred_clr = 1'b0;
        if (!acc) check("accept_timeout", 32'(acc), 32'd1);
        else model_accept(c, sob, clr);
    endtask

    task automatic send_range(input int lo, input int hi, input bit clr, input int gap_pct);
        for (int i = lo; i <= hi; i++) begin
            if ($urandom_range(99) < gap_pct) begin
                @(posedge clk); #1;
            end
            send_coef(blk[i], i == 0, clr && i == 0);
        end
    endtask

    task automatic clear_blk();
        for (int i = 0; i < 64; i++) blk[i] = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() > 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    function automatic int rnd_coef(input int dens);
        int v;
        if (int'($urandom_range(99)) >= dens) return 0;
        if ($urandom_range(1) == 1) v = int'($urandom_range(16)) - 8;
        else v = int'($urandom_range(4095)) - 2048;
        return (v == 0) ? 1 : v;
    endfunction

    // Downstream ready pattern: steady, alternating, or random.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(1));
            endcase
        end
    end

    // Output monitor: every transferred symbol must match the model queue head.
    initial begin
        logic [22:0] cur, held;
        bit stalled;
        stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                cur = {out_dc, out_eob, out_run, out_size, out_amp};
                if (stalled) check("stall_hold", {8'd0, out_valid, cur}, {8'd0, 1'b1, held});
                stalled = 1'b0;
                if (out_valid) begin
                    if (out_ready) begin
                        if (exp_q.size() == 0) check("extra_symbol", 32'(exp_q.size()), 32'd1);
                        else check("symbol", 32'(cur), 32'(exp_q.pop_front()));
                    end else begin
                        stalled = 1'b1;
                        held = cur;
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; pred_clr = 1'b0; in_valid = 1'b0; in_sob = 1'b0; in_coef = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_sync_err", 32'(sync_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("first_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // DC predictor sequence
        clear_blk(); blk[0] = 5; send_range(0, 63, 1'b0, 0);
        clear_blk(); blk[0] = 2; send_range(0, 63, 1'b0, 0);
        // short AC runs
        clear_blk(); blk[0] = 2; blk[3] = -1; blk[10] = 7; send_range(0, 63, 1'b0, 0);
        drain();

        // ZRL flush with in_ready hold-off
        clear_blk(); blk[0] = 1; blk[36] = 1;
        send_range(0, 36, 1'b0, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("flush_in_ready", 32'(in_ready), (k < 3) ? 32'd0 : 32'd1);
        end
        @(posedge clk); #1;
        send_range(37, 63, 1'b0, 0);

        // last coefficient nonzero, then trailing zeros
        clear_blk(); blk[0] = 3; blk[63] = 4; send_range(0, 63, 1'b0, 0);
        clear_blk(); blk[23] = -2; send_range(0, 63, 1'b0, 0);
        drain();

        // backpressure with alternating ready
        rmode = 1;
        clear_blk(); blk[0] = -700; blk[1] = 3; blk[2] = -9; blk[30] = 100; blk[62] = -1;
        send_range(0, 63, 1'b1, 0);
        drain();

        // randomized blocks
        for (int b = 0; b < 30; b++) begin
            int dens;
            rmode = int'($urandom_range(2));
            case ($urandom_range(2))
                0: dens = 50;
                1: dens = 10;
                default: dens = 3;
            endcase
            blk[0] = int'($urandom_range(4095)) - 2048;
            for (int i = 1; i < 64; i++) blk[i] = rnd_coef(dens);
            send_range(0, 63, $urandom_range(4) == 0, 10);
        end
        rmode = 0;
        drain();

        // resync: start-of-block at index 20
        clear_blk(); blk[0] = 10; send_range(0, 19, 1'b0, 0);
        send_coef(-6, 1'b1, 1'b0);
        @(negedge clk);
        check("sync_err_set", 32'(sync_err), 32'd1);
        @(posedge clk); #1;
        clear_blk(); send_range(1, 63, 1'b0, 0);
        drain();
        check("sync_err_sticky", 32'(sync_err), 32'd1);

        // reset while flushing ZRLs
        clear_blk(); blk[0] = 9; blk[40] = 5; send_range(0, 40, 1'b0, 0);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check("midflush_out_valid", 32'(out_valid), 32'd0);
        check("midflush_in_ready", 32'(in_ready), 32'd0);
        check("midflush_sync_err", 32'(sync_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        clear_blk(); blk[0] = 7; blk[5] = -3; send_range(0, 63, 1'b0, 0);
        drain();
        repeat (3) @(posedge clk);
        check("leftover_symbols", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
